datapath: RTL and testbench

Register-transfer datapath of the K&S processor, the direct consumer of every control strobe the `control_unit` FSM produces and the producer of the decoded instruction and registered ALU flags that FSM branches on. It holds the PC, the IR, a 4x16-bit register file, a 16-bit ALU and a flags register. It also drives the RAM address and write-data buses. All state updates are single-cycle register loads qualified by control strobes; there is no internal FSM beyond those registers.

---
 rtl/datapath.sv | 191 +++++++++++++++++++
 tb/tb_datapath.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flags register.
// Optional build macro KS_R0_ZERO_EN hardwires R0 to zero.

package datapath_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNZERO,
        I_BNNEG,
        I_BNOV,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;
endpackage

module datapath
    import datapath_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned REG_N  = 4;
    localparam int unsigned REG_AW = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] rf [REG_N];

    logic [REG_AW-1:0] dst_sel;
    logic [REG_AW-1:0] a_sel;
    logic [REG_AW-1:0] b_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W:0]   alu_wide;
    logic              alu_uov;
    logic              alu_sov;
    logic [DATA_W-1:0] wr_data;
    logic              rf_we;
    logic              unused_ir_bit;

    assign unused_ir_bit = ir[7];

    // Opcode decode of the current IR
    always_comb begin
        decoded_instruction = I_NOP;
        case (ir[15:8])
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BOV;
            8'h0A:   decoded_instruction = I_BNZERO;
            8'h0B:   decoded_instruction = I_BNNEG;
            8'h0D:   decoded_instruction = I_BNOV;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // Register field selection; ALU layout unless the instruction packs fields differently
    always_comb begin
        dst_sel = ir[5:4];
        a_sel   = ir[3:2];
        b_sel   = ir[1:0];
        case (decoded_instruction)
            I_LOAD:  dst_sel = ir[6:5];
            I_STORE: a_sel   = ir[6:5];
            I_MOVE: begin
                dst_sel = ir[3:2];
                a_sel   = ir[1:0];
            end
            default: ;
        endcase
    end

`ifdef KS_R0_ZERO_EN
    assign op_a  = (a_sel == '0) ? '0 : rf[a_sel];
    assign op_b  = (b_sel == '0) ? '0 : rf[b_sel];
    assign rf_we = write_reg_enable && (dst_sel != '0);
`else
    assign op_a  = rf[a_sel];
    assign op_b  = rf[b_sel];
    assign rf_we = write_reg_enable;
`endif

    // ALU; bit 16 of the wide result is carry (ADD) or borrow (SUB)
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_uov    = 1'b0;
        alu_sov    = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_wide   = {1'b0, op_a} + {1'b0, op_b};
                alu_result = alu_wide[DATA_W-1:0];
                alu_uov    = alu_wide[DATA_W];
                alu_sov    = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_wide   = {1'b0, op_a} - {1'b0, op_b};
                alu_result = alu_wide[DATA_W-1:0];
                alu_uov    = alu_wide[DATA_W];
                alu_sov    = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND:  alu_result = op_a & op_b;
            default: alu_result = op_a | op_b;
        endcase
    end

    assign wr_data  = c_sel ? data_in : alu_result;
    assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;
    assign data_out = op_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (pc_enable) begin
                pc <= branch ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
            end
            if (ir_enable) begin
                ir <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '{default: '0};
        end else if (rf_we) begin
            rf[dst_sel] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_result == '0);
            neg_op            <= alu_result[DATA_W-1];
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expected observations, a negedge monitor checks them.
module tb_datapath;
    import datapath_pkg::*;

    localparam int K_ADDR  = 0;
    localparam int K_DOUT  = 1;
    localparam int K_DEC   = 2;
    localparam int K_FLAGS = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic branch, pc_enable, ir_enable, write_reg_enable;
    logic addr_sel, c_sel, flags_reg_enable;
    logic [1:0] operation;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0] ram_addr;
    logic [15:0] data_out, data_in;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          checks = 0;
    int          failures = 0;
    logic [4:0]  m_pc;

    datapath dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the DUT outputs at the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                K_ADDR:  mon_act = 32'(ram_addr);
                K_DOUT:  mon_act = 32'(data_out);
                K_DEC:   mon_act = 32'(decoded_instruction);
                default: mon_act = 32'({zero_op, neg_op, unsigned_overflow, signed_overflow});
            endcase
            checks++;
            if (mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] instr);
        data_in   = instr;
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        branch    = 1'b0;
        tick();
        ir_enable = 1'b0;
        pc_enable = 1'b0;
        m_pc      = m_pc + 5'd1;
    endtask

    task automatic exec(input logic [1:0] op, input logic fl, input logic wr);
        operation        = op;
        flags_reg_enable = fl;
        write_reg_enable = wr;
        c_sel            = 1'b0;
        tick();
        flags_reg_enable = 1'b0;
        write_reg_enable = 1'b0;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        fetch({8'h81, 1'b0, r, 5'd0});
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        data_in          = val;
        tick();
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] r, input logic [15:0] val);
        fetch({8'h82, 1'b0, r, 5'd0});
        expect_val(name, K_DOUT, 32'(val));
        tick();
    endtask

    logic [7:0] dec_opc [6];
    decoded_instruction_type dec_exp [6];
    logic [15:0] r0_sub_exp;
    logic [15:0] r0_move_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_opc = '{8'h05, 8'h0D, 8'h91, 8'hFF, 8'h77, 8'h0A};
        dec_exp = '{I_BOV, I_BNOV, I_MOVE, I_HALT, I_NOP, I_BNZERO};
`ifdef KS_R0_ZERO_EN
        r0_sub_exp  = 16'h0000;
        r0_move_exp = 16'h0000;
`else
        r0_sub_exp  = 16'hFFFE;
        r0_move_exp = 16'h00AA;
`endif
        rst_n = 1'b0;
        branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; write_reg_enable = 1'b0;
        addr_sel = 1'b0; c_sel = 1'b0; operation = 2'b00; flags_reg_enable = 1'b0;
        data_in = 16'h0000;
        m_pc = 5'd0;
        tick();
        expect_val("reset_addr", K_ADDR, 32'd0);
        expect_val("reset_dout", K_DOUT, 32'd0);
        expect_val("reset_dec", K_DEC, 32'(I_NOP));
        expect_val("reset_flags", K_FLAGS, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-run: R2=0x1234, zero flag set, PC=0x0C
        load_reg(2'd2, 16'h1234);
        fetch(16'hA20A);
        exec(2'b01, 1'b1, 1'b0);
        while (m_pc != 5'd12) fetch(16'hA20A);
        expect_val("pre_reset_pc", K_ADDR, 32'd12);
        expect_val("pre_reset_flags", K_FLAGS, 32'h8);
        expect_val("pre_reset_dec", K_DEC, 32'(I_SUB));
        tick();
        #2;
        rst_n = 1'b0;
        m_pc  = 5'd0;
        expect_val("midreset_addr", K_ADDR, 32'd0);
        expect_val("midreset_flags", K_FLAGS, 32'h0);
        expect_val("midreset_dec", K_DEC, 32'(I_NOP));
        expect_val("midreset_dout", K_DOUT, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        read_reg("midreset_r2", 2'd2, 16'h0000);

        // Fetch at PC=31 wraps to 0
        while (m_pc != 5'd31) fetch(16'h0000);
        expect_val("pc31", K_ADDR, 32'd31);
        tick();
        fetch(16'hA1E6);
        expect_val("wrap_pc", K_ADDR, 32'd0);
        expect_val("wrap_dec", K_DEC, 32'(I_ADD));
        tick();
        addr_sel = 1'b1;
        expect_val("wrap_ir_addr", K_ADDR, 32'd6);
        tick();
        addr_sel = 1'b0;

        // ADD signed overflow: R3 = 0x7FFF + 0x0001
        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        fetch(16'hA136);
        exec(2'b00, 1'b1, 1'b1);
        expect_val("add_flags", K_FLAGS, 32'h5);
        tick();
        read_reg("add_r3", 2'd3, 16'h8000);

        // SUB borrow: R0 = R0 - R1
        load_reg(2'd0, 16'h0003);
        load_reg(2'd1, 16'h0005);
        fetch(16'hA201);
        exec(2'b01, 1'b1, 1'b1);
        expect_val("sub_flags", K_FLAGS, 32'h6);
        tick();
        read_reg("sub_r0", 2'd0, r0_sub_exp);

        // LOAD then STORE through address 9
        fetch(16'h8149);
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        data_in          = 16'hBEEF;
        expect_val("load_addr", K_ADDR, 32'd9);
        expect_val("load_dec", K_DEC, 32'(I_LOAD));
        tick();
        write_reg_enable = 1'b0;
        c_sel            = 1'b0;
        fetch(16'h8249);
        expect_val("store_addr", K_ADDR, 32'd9);
        expect_val("store_dout", K_DOUT, 32'hBEEF);
        expect_val("store_dec", K_DEC, 32'(I_STORE));
        tick();
        addr_sel = 1'b0;

        // MOVE R0 <- R1 via OR; flags update regardless of destination
        load_reg(2'd1, 16'h00AA);
        fetch(16'h9101);
        exec(2'b11, 1'b1, 1'b1);
        expect_val("move_flags", K_FLAGS, 32'h0);
        tick();
        read_reg("move_r0", 2'd0, r0_move_exp);

        // AND to zero, then flags hold when not enabled
        load_reg(2'd2, 16'h0055);
        fetch(16'hA336);
        exec(2'b10, 1'b1, 1'b1);
        expect_val("and_flags", K_FLAGS, 32'h8);
        tick();
        exec(2'b00, 1'b0, 1'b0);
        expect_val("flags_hold", K_FLAGS, 32'h8);
        tick();
        read_reg("and_r3", 2'd3, 16'h0000);

        // ADD carry to zero: 0xFFFF + 0x0001
        load_reg(2'd1, 16'hFFFF);
        load_reg(2'd2, 16'h0001);
        fetch(16'hA136);
        exec(2'b00, 1'b1, 1'b0);
        expect_val("carry_flags", K_FLAGS, 32'hA);
        tick();

        // Branch: no effect without pc_enable, then load IR[4:0]
        fetch(16'h0114);
        expect_val("branch_dec", K_DEC, 32'(I_BRANCH));
        branch = 1'b1;
        tick();
        expect_val("branch_hold_pc", K_ADDR, 32'(m_pc));
        pc_enable = 1'b1;
        tick();
        pc_enable = 1'b0;
        branch    = 1'b0;
        m_pc      = 5'h14;
        expect_val("branch_pc", K_ADDR, 32'h14);
        tick();

        // Decode table
        for (int i = 0; i < 6; i++) begin
            fetch({dec_opc[i], 8'h00});
            expect_val($sformatf("decode_%02h", dec_opc[i]), K_DEC, 32'(dec_exp[i]));
            tick();
        end

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
